// File: rtl/cpu_pkg.sv
// Shared constants, lane-state encoding and helpers for the 1-to-8 buffered demux.
package cpu_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry output buffer for a single demux lane; 1-cycle latency.
// Backpressure: a FULL lane holds its word until rd_ready; a same-edge write refills it with no bubble.
module demux_lane_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  lane_state_e state_q;
  lane_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // wr_en is only asserted on a FULL lane when rd_ready is also high, so FULL+wr_en stays FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LANE_EMPTY: if (wr_en)              state_d = LANE_FULL;
      LANE_FULL:  if (rd_ready && !wr_en) state_d = LANE_EMPTY;
      default:                            state_d = LANE_EMPTY;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    if (state_q == LANE_FULL) valid = 1'b1;
  end

  // Word is left untouched when the lane drains; consumers qualify with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (wr_en) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/demux1to8_buf.sv
// Routes one valid/ready source to eight one-entry buffered lanes; 1-cycle latency.
// Backpressure: in_ready follows the selected lane only; stalled offers are counted in drop_cnt (saturating).
module demux1to8_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic [DATA_W-1:0] out_data5,
  output logic [DATA_W-1:0] out_data6,
  output logic [DATA_W-1:0] out_data7,
  output logic [LANES-1:0]  out_valid,
  input  logic [LANES-1:0]  out_ready,
  output logic [7:0]        drop_cnt
);

  logic [LANES-1:0]  lane_wr;
  logic [DATA_W-1:0] lane_data [LANES];

  // Derived from lane state and consumer ready only, never from in_valid.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_wr[i] = in_valid && in_ready && (in_sel == SEL_W'(i));

    demux_lane_buf #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (lane_wr[i]),
      .wr_data  (in_data),
      .rd_ready (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (lane_data[i])
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];
  assign out_data4 = lane_data[4];
  assign out_data5 = lane_data[5];
  assign out_data6 = lane_data[6];
  assign out_data7 = lane_data[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if (in_valid && !in_ready) begin
      drop_cnt <= sat_inc8(drop_cnt);
    end
  end

endmodule
